// File: rtl/uart_fw_pkg.sv
// Shared types and constants for the UART firmware loader.
// Holds the FSM state enum, UART register map, flag masks, reply codes and the CRC step.
package uart_fw_pkg;

  typedef enum logic [3:0] {
    S_INIT_CTRL,
    S_INIT_BAUD,
    S_PKT_START,
    S_POLL,
    S_RD_RX,
    S_CLR,
    S_CHECK,
    S_HDR,
    S_WRITE,
    S_ACK,
    S_NAK,
    S_TX,
    S_DONE
  } state_e;

  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_BAUD   = 32'h8;
  localparam logic [31:0] OFF_TX     = 32'hC;
  localparam logic [31:0] OFF_RX     = 32'h10;

  localparam logic [31:0] TX_BUSY = 32'h1;
  localparam logic [31:0] RX_OVER = 32'h2;

  localparam logic [7:0] ACK_CODE = 8'h06;
  localparam logic [7:0] NAK_CODE = 8'h15;

  // CRC-16/MODBUS, one byte per call, reflected poly 0xA001
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  data
  );
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_fw_loader_bus_if.sv
// Single-access bus master: latches addr/we/wdata on start, holds req until gnt.
// Ports: start_i/we_i/addr_i/wdata_i request side; req/we/addr/wdata/gnt/rdata bus side; done_o pulse.
module uart_fw_bus_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic [31:0] rdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o
);

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (req_q) begin
      if (gnt_i) req_d = 1'b0;
    end else if (start_i) begin
      req_d   = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // gnt completes the access in the same cycle; read data is live then
  assign done_o  = req_q & gnt_i;
  assign rdata_o = rdata_i;
  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/uart_fw_loader.sv
// UART firmware loader: programs the UART, receives CRC-checked packets, writes payload to memory.
// Ports: clk/rst/en_i control; req/gnt/we/addr/wdata/rdata bus master; busy_o, done_o, err_cnt_o status.
module uart_fw_loader #(
  parameter int          PAYLOAD_BYTES = 128,
  parameter logic [31:0] UART_BASE     = 32'h3000_0000,
  parameter logic [31:0] BAUD_DIV      = 32'h1B8,
  parameter logic [31:0] MEM_BASE      = 32'h0,
  parameter int unsigned TIMEOUT_CYC   = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic        req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  err_cnt_o
);

  import uart_fw_pkg::*;

  localparam int          PKT_LEN  = PAYLOAD_BYTES + 3;
  localparam int          IW       = $clog2(PKT_LEN);
  localparam int          CRC_IDX  = PAYLOAD_BYTES + 1;
  localparam logic [7:0]  LAST_IDX = 8'(PKT_LEN);
  localparam logic [7:0]  CRC_LIM  = 8'(CRC_IDX);
  localparam logic [7:0]  PL_WORDS = 8'(PAYLOAD_BYTES / 4);
  localparam logic [31:0] PL32     = 32'(PAYLOAD_BYTES);
  localparam logic [31:0] TMO      = 32'(TIMEOUT_CYC);
  localparam bit          PL_POW2  = (PAYLOAD_BYTES & (PAYLOAD_BYTES - 1)) == 0;
  localparam int          PL_SHIFT = $clog2(PAYLOAD_BYTES);

  logic srst;
  assign srst = rst | ~en_i;

  state_e      state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic        hdr_q, hdr_d;
  logic [31:0] size_q, size_d;
  logic [23:0] total_q, total_d;
  logic [23:0] pdone_q, pdone_d;
  logic [31:0] woff_q, woff_d;
  logic [7:0]  widx_q, widx_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] crc_q, crc_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  code_q, code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  err_q, err_d;
  logic [31:0] hrem_q, hrem_d;
  logic [7:0]  pkt_q [PKT_LEN];
  logic [7:0]  pkt_d [PKT_LEN];

  logic        start;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        bus_done;
  logic [31:0] bus_rdata;

  uart_fw_bus_if u_bus (
    .clk     (clk),
    .rst     (srst),
    .start_i (start),
    .we_i    (acc_we),
    .addr_i  (acc_addr),
    .wdata_i (acc_wdata),
    .req_o   (req_o),
    .we_o    (mem_we_o),
    .addr_o  (mem_addr_o),
    .wdata_o (mem_wdata_o),
    .gnt_i   (mem_gnt_i),
    .rdata_i (mem_rdata_i),
    .done_o  (bus_done),
    .rdata_o (bus_rdata)
  );

  logic [31:0] size_w;
  logic [32:0] hsum;
  logic        armed;
  logic        crc_ok;
  logic        last_pkt;
  logic [31:0] rem;
  logic [7:0]  nwords;
  logic [31:0] wword;
  logic [7:0]  bi0, bi1, bi2, bi3;

  assign size_w   = {pkt_q[4], pkt_q[3], pkt_q[2], pkt_q[1]};
  assign hsum     = {1'b0, size_w} + 33'(PAYLOAD_BYTES - 1);
  // the first byte of a packet may take arbitrarily long
  assign armed    = idx_q != 8'd0;
  assign crc_ok   = crc_q == {pkt_q[CRC_IDX+1], pkt_q[CRC_IDX]};
  assign last_pkt = (pdone_q + 24'd1) == total_q;
  assign rem      = size_q - (woff_q << 2);
  assign nwords   = last_pkt ? 8'((rem + 32'd3) >> 2) : PL_WORDS;
  assign wword    = woff_q + {24'd0, widx_q};
  assign bi0      = 8'd1 + {widx_q[5:0], 2'b00};
  assign bi1      = bi0 + 8'd1;
  assign bi2      = bi0 + 8'd2;
  assign bi3      = bi0 + 8'd3;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    hdr_d     = hdr_q;
    size_d    = size_q;
    total_d   = total_q;
    pdone_d   = pdone_q;
    woff_d    = woff_q;
    widx_d    = widx_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    tmo_d     = tmo_q;
    code_d    = code_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    hrem_d    = hrem_q;
    pkt_d     = pkt_q;
    start     = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = UART_BASE + OFF_STATUS;
    acc_wdata = '0;

    unique case (state_q)
      S_INIT_CTRL: begin
        start     = ~req_o;
        acc_we    = 1'b1;
        acc_addr  = UART_BASE + OFF_CTRL;
        acc_wdata = 32'd3;
        if (bus_done) state_d = S_INIT_BAUD;
      end
      S_INIT_BAUD: begin
        start     = ~req_o;
        acc_we    = 1'b1;
        acc_addr  = UART_BASE + OFF_BAUD;
        acc_wdata = BAUD_DIV;
        if (bus_done) state_d = S_PKT_START;
      end
      S_PKT_START: begin
        idx_d   = '0;
        crc_d   = 16'hFFFF;
        tmo_d   = TMO;
        state_d = S_POLL;
      end
      S_POLL: begin
        start = ~req_o;
        if (armed && tmo_q != 0) tmo_d = tmo_q - 32'd1;
        // leave only on an access boundary so no stale done leaks out
        if (bus_done) begin
          if ((bus_rdata & RX_OVER) != 0) state_d = S_RD_RX;
          else if (armed && tmo_q == 0) state_d = S_NAK;
        end
      end
      S_RD_RX: begin
        start    = ~req_o;
        acc_addr = UART_BASE + OFF_RX;
        if (bus_done) begin
          pkt_d[idx_q[IW-1:0]] = bus_rdata[7:0];
          if (idx_q < CRC_LIM)
            crc_d = crc16_byte(crc_q, bus_rdata[7:0]);
          idx_d   = idx_q + 8'd1;
          tmo_d   = TMO;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        start  = ~req_o;
        acc_we = 1'b1;
        if (bus_done)
          state_d = (idx_q == LAST_IDX) ? S_CHECK : S_POLL;
      end
      S_CHECK: begin
        if (!crc_ok) begin
          state_d = S_NAK;
        end else if (pkt_q[0] == exp_q) begin
          if (exp_q == 8'd0 && !hdr_q) begin
            hrem_d  = size_w;
            total_d = '0;
            state_d = S_HDR;
          end else begin
            widx_d  = '0;
            state_d = S_WRITE;
          end
        end else if (exp_q != 8'd0 && pkt_q[0] == exp_q - 8'd1) begin
          state_d = S_ACK;
        end else begin
          state_d = S_NAK;
        end
      end
      S_HDR: begin
        size_d = size_w;
        if (PL_POW2 || hrem_q == 0) begin
          if (PL_POW2) total_d = 24'(hsum >> PL_SHIFT);
          exp_d   = 8'd1;
          hdr_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_ACK;
        end else begin
          total_d = total_q + 24'd1;
          hrem_d  = (hrem_q > PL32) ? hrem_q - PL32 : '0;
        end
      end
      S_WRITE: begin
        start     = ~req_o;
        acc_we    = 1'b1;
        acc_addr  = MEM_BASE + (wword << 2);
        acc_wdata = {pkt_q[bi3[IW-1:0]], pkt_q[bi2[IW-1:0]],
                     pkt_q[bi1[IW-1:0]], pkt_q[bi0[IW-1:0]]};
        if (bus_done) begin
          if (widx_q + 8'd1 == nwords) begin
            exp_d   = exp_q + 8'd1;
            woff_d  = woff_q + {24'd0, PL_WORDS};
            pdone_d = pdone_q + 24'd1;
            widx_d  = '0;
            state_d = S_ACK;
          end else begin
            widx_d = widx_q + 8'd1;
          end
        end
      end
      S_ACK, S_NAK: begin
        start = ~req_o;
        if (bus_done && (bus_rdata & TX_BUSY) == 0) begin
          code_d  = (state_q == S_ACK) ? ACK_CODE : NAK_CODE;
          state_d = S_TX;
        end
      end
      S_TX: begin
        start     = ~req_o;
        acc_we    = 1'b1;
        acc_addr  = UART_BASE + OFF_TX;
        acc_wdata = {24'd0, code_q};
        if (bus_done) begin
          state_d = S_PKT_START;
          if (code_q == NAK_CODE) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end else if (hdr_q && pdone_q == total_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_INIT_CTRL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_INIT_CTRL;
      exp_q   <= '0;
      hdr_q   <= 1'b0;
      size_q  <= '0;
      total_q <= '0;
      pdone_q <= '0;
      woff_q  <= '0;
      widx_q  <= '0;
      idx_q   <= '0;
      crc_q   <= 16'hFFFF;
      tmo_q   <= '0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      hrem_q  <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      hdr_q   <= hdr_d;
      size_q  <= size_d;
      total_q <= total_d;
      pdone_q <= pdone_d;
      woff_q  <= woff_d;
      widx_q  <= widx_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hrem_q  <= hrem_d;
    end
  end

  // packet buffer is pure data, only meaningful after a full packet
  always_ff @(posedge clk) begin
    pkt_q <= pkt_d;
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_cnt_o = err_q;

endmodule
